// File: rtl/steer_en_gen.sv
// Rider-detect / steering-enable controller between the load-cell A2D and balance_cntrl.
// Latency: 2 clk from lft_ld/rght_ld to ld_cell_diff, en_steer and rider_off.
// Backpressure: none; samples are taken every clk and outputs are always valid.
module steer_en_gen #(
    parameter int unsigned         LD_W         = 12,
    parameter int unsigned         TMR_CYCLES   = 65000000,
    parameter logic [LD_W-1:0]     MIN_RIDER_WT = LD_W'(32'h200),
    parameter logic [LD_W-1:0]     HYST         = LD_W'(32'h020),
    parameter int unsigned         SETTLE_SHIFT = 2,
    parameter int unsigned         OFF_NUM      = 15,
    parameter int unsigned         OFF_SHIFT    = 4,
    parameter int unsigned         OFF_DBNC     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [LD_W-1:0] lft_ld,
    input  logic [LD_W-1:0] rght_ld,
    output logic [LD_W-1:0] ld_cell_diff,
    output logic            en_steer,
    output logic            rider_off,
    output logic            tmr_full
);

    // Comparison width holds sum*OFF_NUM for any 32-bit OFF_NUM without overflow.
    localparam int unsigned CW = LD_W + 33;
    localparam int unsigned TW = (TMR_CYCLES > 1) ? $clog2(TMR_CYCLES) : 1;
    localparam int unsigned DW = $clog2(OFF_DBNC + 1);

    localparam logic [TW-1:0] TMR_MAX   = TW'(TMR_CYCLES - 1);
    localparam logic [DW-1:0] DBNC_LAST = DW'(OFF_DBNC - 1);
    localparam logic [DW-1:0] DBNC_MAX  = DW'(OFF_DBNC);
    localparam logic [CW-1:0] MIN_W     = CW'(MIN_RIDER_WT);
    localparam logic [CW-1:0] HYST_W    = CW'(HYST);
    localparam logic [CW-1:0] NUM_W     = CW'(OFF_NUM);
    localparam logic [CW-1:0] THR_HI    = MIN_W + HYST_W;

    typedef enum logic [1:0] {IDLE, WAIT, STEER_EN} state_t;

    state_t                state, nxt_state;
    logic [LD_W-1:0]       l_q, r_q;
    logic [LD_W:0]         sum;
    logic signed [LD_W:0]  sub;
    logic [LD_W:0]         mag;
    logic [CW-1:0]         sum_w, diff_w;
    logic                  heavy, light, unsettled, stepping;
    logic [TW-1:0]         timer;
    logic [DW-1:0]         dbnc_cnt, dbnc_nxt;
    logic                  clr_tmr, step_off;

    assign sum    = {1'b0, l_q} + {1'b0, r_q};
    assign sub    = $signed({1'b0, l_q}) - $signed({1'b0, r_q});
    assign mag    = sub[LD_W] ? $unsigned(-sub) : $unsigned(sub);
    assign sum_w  = CW'(sum);
    assign diff_w = CW'(mag);

    // Low threshold written as sum+HYST < MIN so it cannot underflow.
    assign heavy     = sum_w > THR_HI;
    assign light     = (sum_w + HYST_W) < MIN_W;
    assign unsettled = diff_w > (sum_w >> SETTLE_SHIFT);
    assign stepping  = diff_w > ((sum_w * NUM_W) >> OFF_SHIFT);

    assign tmr_full = (timer == TMR_MAX);
    assign step_off = (state == STEER_EN) && stepping && (dbnc_cnt == DBNC_LAST);

    always_comb begin
        dbnc_nxt = '0;
        if (state == STEER_EN && stepping) begin
            dbnc_nxt = (dbnc_cnt == DBNC_MAX) ? dbnc_cnt : dbnc_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt_state = state;
        clr_tmr   = 1'b0;
        case (state)
            IDLE: begin
                if (heavy) begin
                    nxt_state = WAIT;
                    clr_tmr   = 1'b1;
                end
            end
            WAIT: begin
                if (light) begin
                    nxt_state = IDLE;
                end else if (unsettled) begin
                    clr_tmr = 1'b1;
                end else if (tmr_full) begin
                    nxt_state = STEER_EN;
                end
            end
            STEER_EN: begin
                if (light) begin
                    nxt_state = IDLE;
                end else if (step_off) begin
                    nxt_state = WAIT;
                    clr_tmr   = 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q          <= '0;
            r_q          <= '0;
            ld_cell_diff <= '0;
            state        <= IDLE;
            timer        <= '0;
            dbnc_cnt     <= '0;
            en_steer     <= 1'b0;
            rider_off    <= 1'b0;
        end else begin
            l_q          <= lft_ld;
            r_q          <= rght_ld;
            ld_cell_diff <= mag[LD_W-1:0];
            state        <= nxt_state;
            dbnc_cnt     <= dbnc_nxt;
            // en_steer tracks the state register exactly, so it is loaded from nxt_state.
            en_steer     <= (nxt_state == STEER_EN);
            rider_off    <= (state != IDLE) && (nxt_state == IDLE);
            if (clr_tmr || state == IDLE) begin
                timer <= '0;
            end else if (timer != TMR_MAX) begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_steer_en_gen.sv
// Directed bench for steer_en_gen with a cycle-indexed scoreboard.
module tb_steer_en_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] lft_ld, rght_ld, ld_cell_diff;
    logic        en_steer, rider_off, tmr_full;

    typedef enum logic [1:0] {S_DIFF, S_EN, S_OFF, S_FULL} sig_e;
    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [11:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    steer_en_gen #(
        .LD_W(12),
        .TMR_CYCLES(16),
        .MIN_RIDER_WT(12'h200),
        .HYST(12'h020)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .lft_ld(lft_ld),
        .rght_ld(rght_ld),
        .ld_cell_diff(ld_cell_diff),
        .en_steer(en_steer),
        .rider_off(rider_off),
        .tmr_full(tmr_full)
    );

    function automatic logic [11:0] actual(input sig_e s);
        case (s)
            S_DIFF:  return ld_cell_diff;
            S_EN:    return {11'h0, en_steer};
            S_OFF:   return {11'h0, rider_off};
            default: return {11'h0, tmr_full};
        endcase
    endfunction

    function automatic string sig_name(input sig_e s);
        case (s)
            S_DIFF:  return "ld_cell_diff";
            S_EN:    return "en_steer";
            S_OFF:   return "rider_off";
            default: return "tmr_full";
        endcase
    endfunction

    task automatic expect_at(input int at, input sig_e s, input logic [11:0] v);
        exp_t e;
        e.cyc = at;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic expect_span(input int from, input int to, input sig_e s, input logic [11:0] v);
        for (int k = from; k <= to; k++) expect_at(k, s, v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
    endtask

    // Monitor: every negedge, check all expectations due in this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [11:0] a;
                a = actual(sb[i].sig);
                n_tests++;
                if (a !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h",
                             sig_name(sb[i].sig), cyc, a, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        int b;
        rst_n = 1'b0;
        drive(12'h300, 12'h300);

        // Reset held with a heavy rider: everything stays cleared.
        tick(1);
        n_tests++;
        if (en_steer !== 1'b0) begin
            n_fail++;
            $display("FAIL en_steer in reset: got %0b", en_steer);
        end
        n_tests++;
        if (rider_off !== 1'b0) begin
            n_fail++;
            $display("FAIL rider_off in reset: got %0b", rider_off);
        end
        n_tests++;
        if (tmr_full !== 1'b0) begin
            n_fail++;
            $display("FAIL tmr_full in reset: got %0b", tmr_full);
        end
        n_tests++;
        if (ld_cell_diff !== 12'h0) begin
            n_fail++;
            $display("FAIL ld_cell_diff in reset: got 0x%0h", ld_cell_diff);
        end
        expect_span(cyc + 1, cyc + 3, S_EN,   12'h0);
        expect_span(cyc + 1, cyc + 3, S_OFF,  12'h0);
        expect_span(cyc + 1, cyc + 3, S_FULL, 12'h0);
        expect_span(cyc + 1, cyc + 3, S_DIFF, 12'h0);
        tick(3);

        // Release, then balanced 0x180/0x180: WAIT from b+2, tmr_full b+17, en_steer b+18.
        rst_n = 1'b1;
        b = cyc;
        expect_at(b + 2, S_DIFF, 12'h0);
        expect_span(b + 1, b + 21, S_OFF, 12'h0);
        expect_span(b + 1, b + 17, S_EN, 12'h0);
        expect_at(b + 16, S_FULL, 12'h0);
        expect_at(b + 17, S_FULL, 12'h1);
        expect_at(b + 18, S_EN, 12'h1);
        tick(1);
        drive(12'h180, 12'h180);
        tick(20);

        // Step-off held 3 cycles: debounce does not fire.
        b = cyc;
        drive(12'h2F8, 12'h008);
        expect_at(b + 2, S_DIFF, 12'h2F0);
        expect_span(b + 1, b + 8, S_EN, 12'h1);
        expect_at(b + 6, S_DIFF, 12'h0);
        tick(3);
        drive(12'h180, 12'h180);
        tick(5);

        // Step-off held 4 cycles: WAIT at b+5, full 16-cycle re-enable.
        b = cyc;
        drive(12'h2F8, 12'h008);
        expect_span(b + 1, b + 4, S_EN, 12'h1);
        expect_span(b + 5, b + 20, S_EN, 12'h0);
        expect_at(b + 21, S_EN, 12'h1);
        expect_span(b + 1, b + 24, S_OFF, 12'h0);
        expect_at(b + 4, S_FULL, 12'h1);
        expect_at(b + 5, S_FULL, 12'h0);
        expect_at(b + 19, S_FULL, 12'h0);
        expect_at(b + 20, S_FULL, 12'h1);
        tick(4);
        drive(12'h180, 12'h180);
        tick(20);

        // Sum in hysteresis band keeps STEER_EN; light sum drops to IDLE with one pulse.
        b = cyc;
        drive(12'h0F8, 12'h0F8);
        expect_span(b + 1, b + 7, S_EN, 12'h1);
        expect_span(b + 1, b + 7, S_OFF, 12'h0);
        expect_span(b + 8, b + 18, S_EN, 12'h0);
        expect_at(b + 8, S_OFF, 12'h1);
        expect_span(b + 9, b + 18, S_OFF, 12'h0);
        tick(6);
        drive(12'h0E0, 12'h0E0);
        tick(12);

        // WAIT with 10 unsettled cycles holding the timer at zero.
        b = cyc;
        drive(12'h180, 12'h180);
        expect_at(b + 7, S_DIFF, 12'h100);
        expect_at(b + 16, S_DIFF, 12'h100);
        expect_at(b + 17, S_DIFF, 12'h0);
        expect_at(b + 16, S_FULL, 12'h0);
        expect_at(b + 30, S_FULL, 12'h0);
        expect_at(b + 31, S_FULL, 12'h1);
        expect_span(b + 1, b + 31, S_EN, 12'h0);
        expect_at(b + 32, S_EN, 12'h1);
        expect_span(b + 1, b + 32, S_OFF, 12'h0);
        tick(5);
        drive(12'h200, 12'h100);
        tick(10);
        drive(12'h180, 12'h180);
        tick(17);

        // Full-scale difference, then light exit from STEER_EN.
        b = cyc;
        drive(12'hFFF, 12'h000);
        expect_at(b + 2, S_DIFF, 12'hFFF);
        expect_at(b + 3, S_DIFF, 12'hFFF);
        expect_at(b + 3, S_EN, 12'h1);
        expect_at(b + 4, S_EN, 12'h0);
        expect_at(b + 4, S_OFF, 12'h1);
        expect_at(b + 5, S_OFF, 12'h0);
        tick(2);
        drive(12'h000, 12'h000);
        tick(4);

        // Both at full scale is heavy; reset at timer=9 restarts the count.
        b = cyc;
        drive(12'hFFF, 12'hFFF);
        expect_at(b + 2, S_DIFF, 12'h0);
        expect_at(b + 10, S_FULL, 12'h0);
        expect_span(b + 1, b + 10, S_EN, 12'h0);
        expect_span(b + 1, b + 31, S_OFF, 12'h0);
        tick(11);
        rst_n = 1'b0;
        expect_at(b + 12, S_EN, 12'h0);
        expect_at(b + 12, S_FULL, 12'h0);
        expect_at(b + 12, S_DIFF, 12'h0);
        tick(2);
        n_tests++;
        if (en_steer !== 1'b0) begin
            n_fail++;
            $display("FAIL en_steer in mid-WAIT reset: got %0b", en_steer);
        end
        n_tests++;
        if (rider_off !== 1'b0) begin
            n_fail++;
            $display("FAIL rider_off in mid-WAIT reset: got %0b", rider_off);
        end
        n_tests++;
        if (ld_cell_diff !== 12'h0) begin
            n_fail++;
            $display("FAIL ld_cell_diff in mid-WAIT reset: got 0x%0h", ld_cell_diff);
        end
        rst_n = 1'b1;
        expect_span(b + 14, b + 30, S_EN, 12'h0);
        expect_at(b + 29, S_FULL, 12'h0);
        expect_at(b + 30, S_FULL, 12'h1);
        expect_at(b + 31, S_EN, 12'h1);
        tick(20);

        tick(3);
        #1;
        foreach (sb[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s cycle %0d: got no check, want 0x%0h", sig_name(sb[i].sig), sb[i].cyc, sb[i].val);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/steer_en_gen.md
Name: steer_en_gen

Overview:
Parametrised rider-detect / steering-enable controller, next generation of the load-cell steering gate. It sits between the A2D interface, which supplies the left and right load-cell readings, and balance_cntrl, which consumes en_steer, rider_off and ld_cell_diff. Compared with the earlier block it adds:
- generic load-cell width and timer length
- configurable settle and step-off fractions
- hysteresis on the rider-weight threshold
- debounce of the step-off condition
- a single-cycle rider_off pulse
- registered, overflow-free arithmetic

Parameters:
LD_W, 12, load-cell sample width (unsigned)
TMR_CYCLES, 65000000, clk cycles of stable stance before steering enables (1.3 s at 50 MHz)
MIN_RIDER_WT, 12'h200, nominal rider-weight threshold on lft_ld+rght_ld
HYST, 12'h020, hysteresis half-band around MIN_RIDER_WT
SETTLE_SHIFT, 2, rider unsettled if |diff| > sum>>SETTLE_SHIFT (1/4)
OFF_NUM, 15, step-off fraction numerator
OFF_SHIFT, 4, step-off fraction denominator as shift (15/16)
OFF_DBNC, 4, consecutive cycles the step-off condition must hold

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
lft_ld  in  LD_W  left load cell, unsigned
rght_ld  in  LD_W  right load cell, unsigned
ld_cell_diff  out  LD_W  registered |lft_ld - rght_ld|
en_steer  out  1  high while in STEER_EN
rider_off  out  1  one-cycle pulse when the rider leaves
tmr_full  out  1  stance timer reached terminal count (debug)

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All flops clear on reset.
- Reset values: state=IDLE, ld_cell_diff=0, en_steer=0, rider_off=0, tmr_full=0, timer=0, debounce count=0, input registers=0.
- Stage 1 registers the inputs as l_q and r_q.
- Combinational terms are computed from the stage-1 registers:
  - sum = l_q + r_q at LD_W+1 bits, with no overflow.
  - diff = |l_q - r_q|, taken from an LD_W+1-bit signed subtraction. The result always fits in LD_W bits.
- ld_cell_diff is registered diff, giving 2 cycles of latency from input to output.
- Comparisons are evaluated at full width, with no truncation:
  - heavy = sum > MIN_RIDER_WT+HYST
  - light = sum < MIN_RIDER_WT-HYST
  - unsettled = diff > (sum>>SETTLE_SHIFT)
  - stepping = diff > ((sum*OFF_NUM)>>OFF_SHIFT)
- Timer: width clog2(TMR_CYCLES).
  - Clears when clr_tmr is asserted or when the state is IDLE.
  - Otherwise increments, saturating at TMR_CYCLES-1. It never wraps.
  - tmr_full = (timer == TMR_CYCLES-1).
- FSM states are IDLE, WAIT and STEER_EN.
  - IDLE:
    - heavy -> WAIT, clr_tmr.
    - Otherwise stay.
  - WAIT:
    - light -> IDLE.
    - Else unsettled -> stay, clr_tmr.
    - Else tmr_full -> STEER_EN.
    - Else stay.
  - STEER_EN:
    - light -> IDLE.
    - Else if stepping has held for OFF_DBNC consecutive cycles -> WAIT, clr_tmr.
    - Else stay.
- Priority: light has priority over every other condition in every state.
- Debounce counter:
  - Counts consecutive stepping cycles, in STEER_EN only, and saturates at OFF_DBNC.
  - Clears on any cycle where stepping is 0, and clears outside STEER_EN.
  - The transition fires in the cycle the count would reach OFF_DBNC.
- en_steer: registered. It is 1 exactly in the cycles where the state register is STEER_EN.
- rider_off: registered. It is 1 for exactly one cycle following any WAIT->IDLE or STEER_EN->IDLE transition. It is never high while the FSM simply remains in IDLE.
- Hysteresis: when MIN_RIDER_WT-HYST <= sum <= MIN_RIDER_WT+HYST, the block takes no weight-based transition.
- Timer cycle count: WAIT -> STEER_EN takes exactly TMR_CYCLES settled cycles after the last clr_tmr.
- Reset mid-operation: returns immediately to IDLE, with en_steer=0 and no rider_off pulse.

Test Plan:
Test overrides for all scenarios: TMR_CYCLES=16, MIN=0x200, HYST=0x20. Thresholds are therefore enter >0x220 and exit <0x1E0.
1. Reset with lft/rght=0x300 -> all outputs 0 during reset. 2 cycles after release ld_cell_diff=0. No rider_off pulse at any time.
2. lft=rght=0x180 (sum 0x300) -> WAIT. en_steer rises exactly 16 cycles after entering WAIT, and tmr_full=1 one cycle earlier.
3. In WAIT, lft=0x200, rght=0x100 (diff 0x100 > 0xC0) for 10 cycles, then balanced -> timer held at 0 during the unbalanced cycles. ld_cell_diff=0x100. en_steer 16 cycles after rebalancing.
4. In STEER_EN, lft=0x2F8, rght=0x008 (diff 0x2F0 > 0x2D0):
   - Held 3 cycles, then released -> stays in STEER_EN.
   - Held 4 cycles -> WAIT and en_steer falls. A subsequent re-enable requires a full 16 cycles.
5. In STEER_EN, set sum=0x1F0 -> no change. Then lft=rght=0x0E0 (sum 0x1C0) -> IDLE, with en_steer 0 and rider_off high for exactly 1 cycle. Holding light keeps rider_off at 0.
6. lft=0xFFF, rght=0x000 -> ld_cell_diff=0xFFF with no wrap. Both at 0xFFF -> sum 0x1FFE is heavy. Assert rst_n low mid-WAIT at timer=9 -> IDLE, and the timer restarts from 0.
